// File: rtl/fetch_stage_if.sv
// fetch_stage_if: handshake/bus bundle between the fetch stage, the hazard/branch
// logic, the instruction memory and the decode stage.
//   master (fetch stage): drives Inst_Address, IF/ID outputs, fetch_done, fetch_count;
//                         receives stall, flush, branch_target, Instruction.
//   slave  (environment): mirror image of master.
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] Instruction;
    logic [31:0] Inst_Address;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        fetch_done;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, branch_target, Instruction,
        output Inst_Address, if_id_pc, if_id_instruction, if_id_valid, fetch_done, fetch_count
    );

    modport slave (
        output stall, flush, branch_target, Instruction,
        input  Inst_Address, if_id_pc, if_id_instruction, if_id_valid, fetch_done, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID pipeline register.
// Owns the PC, presents it as the byte address to a combinational instruction memory
// and latches {PC, Instruction} into IF/ID. Priority per edge: flush > stall >
// end-of-program guard > normal fetch.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - fetch_stage_if.master (stall/flush/branch_target/Instruction in;
//           Inst_Address, if_id_pc, if_id_instruction, if_id_valid, fetch_done,
//           fetch_count out)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd84,
    parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [31:0] LastAddr = MEM_BYTES - 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_insn;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_next;
    logic [31:0] w_if_id_pc_next;
    logic [31:0] w_if_id_insn_next;
    logic        w_if_id_valid_next;
    logic [31:0] w_fetch_count_next;
    logic        w_fetch_done;

    // Beyond the last word or misaligned: stop sampling the memory.
    assign w_fetch_done = (r_pc > LastAddr) || (r_pc[1:0] != 2'b00);

    always_comb begin
        w_pc_next          = r_pc;
        w_if_id_pc_next    = r_if_id_pc;
        w_if_id_insn_next  = r_if_id_insn;
        w_if_id_valid_next = r_if_id_valid;
        w_fetch_count_next = r_fetch_count;
        if (bus.flush) begin
            w_pc_next          = {bus.branch_target[31:2], 2'b00};
            w_if_id_pc_next    = 32'd0;
            w_if_id_insn_next  = NOP_INSN;
            w_if_id_valid_next = 1'b0;
        end else if (bus.stall) begin
            // hold everything
        end else if (w_fetch_done) begin
            w_if_id_pc_next    = 32'd0;
            w_if_id_insn_next  = NOP_INSN;
            w_if_id_valid_next = 1'b0;
        end else begin
            w_pc_next          = r_pc + 32'd4;
            w_if_id_pc_next    = r_pc;
            w_if_id_insn_next  = bus.Instruction;
            w_if_id_valid_next = 1'b1;
            w_fetch_count_next = r_fetch_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'd0;
            r_if_id_insn  <= NOP_INSN;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc          <= w_pc_next;
            r_if_id_pc    <= w_if_id_pc_next;
            r_if_id_insn  <= w_if_id_insn_next;
            r_if_id_valid <= w_if_id_valid_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign bus.Inst_Address      = r_pc;
    assign bus.fetch_done        = w_fetch_done;
    assign bus.if_id_pc          = r_if_id_pc;
    assign bus.if_id_instruction = r_if_id_insn;
    assign bus.if_id_valid       = r_if_id_valid;
    assign bus.fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Each step pushes the expected
// IF/ID contents; a monitor pops and compares after the edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        valid;
        logic        chk_pc;
    } sb_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:20];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd84 && a[1:0] == 2'b00) return rom[a[6:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign bus.Instruction = mem_word(bus.Inst_Address);

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    sb_t         m_ifid;
    sb_t         sb [$];
    sb_t         mon_e;

    function automatic logic m_done();
        return (m_pc > 32'd80) || (m_pc[1:0] != 2'b00);
    endfunction

    always @(posedge clk) begin
        if (sb.size() != 0) begin
            #1;
            mon_e = sb.pop_front();
            total++;
            if (bus.if_id_valid !== mon_e.valid) begin
                bad++;
                $display("FAIL sb_valid: got %0b want %0b", bus.if_id_valid, mon_e.valid);
            end
            total++;
            if (bus.if_id_instruction !== mon_e.insn) begin
                bad++;
                $display("FAIL sb_insn: got %h want %h", bus.if_id_instruction, mon_e.insn);
            end
            if (mon_e.chk_pc) begin
                total++;
                if (bus.if_id_pc !== mon_e.pc) begin
                    bad++;
                    $display("FAIL sb_pc: got %h want %h", bus.if_id_pc, mon_e.pc);
                end
            end
        end
    end

    task automatic step(input logic s, input logic f, input logic [31:0] t);
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_target = t;
        if (f) begin
            m_pc   = {t[31:2], 2'b00};
            m_ifid = '{pc: 32'd0, insn: NOP, valid: 1'b0, chk_pc: 1'b1};
        end else if (s) begin
            // IF/ID expected to hold
        end else if (m_done()) begin
            m_ifid = '{pc: 32'd0, insn: NOP, valid: 1'b0, chk_pc: 1'b0};
        end else begin
            m_ifid  = '{pc: m_pc, insn: mem_word(m_pc), valid: 1'b1, chk_pc: 1'b1};
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
        sb.push_back(m_ifid);
        @(posedge clk);
        #2;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset   = 1'b0;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_ifid  = '{pc: 32'd0, insn: NOP, valid: 1'b0, chk_pc: 1'b1};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if (bus.Inst_Address !== 32'd0) begin
            bad++; $display("FAIL rst_addr: got %h want 0", bus.Inst_Address);
        end
        total++;
        if (bus.if_id_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid: got %0b want 0", bus.if_id_valid);
        end
        total++;
        if (bus.if_id_instruction !== NOP) begin
            bad++; $display("FAIL rst_insn: got %h want %h", bus.if_id_instruction, NOP);
        end
        total++;
        if (bus.if_id_pc !== 32'd0) begin
            bad++; $display("FAIL rst_pc: got %h want 0", bus.if_id_pc);
        end
        total++;
        if (bus.fetch_count !== 32'd0 || bus.fetch_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_cnt_done: got %0d/%0b want 0/0", bus.fetch_count, bus.fetch_done);
        end
        do_reset();
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
        total++;
        if (bus.if_id_pc !== 32'd8 || bus.if_id_instruction !== 32'h00A0_0513
            || bus.if_id_valid !== 1'b1) begin
            bad++;
            $display("FAIL run_ifid: got %h/%h/%0b want 8/00a00513/1",
                     bus.if_id_pc, bus.if_id_instruction, bus.if_id_valid);
        end
        total++;
        if (bus.fetch_count !== 32'd3 || bus.Inst_Address !== 32'd12) begin
            bad++;
            $display("FAIL run_cnt_addr: got %0d/%0d want 3/12", bus.fetch_count, bus.Inst_Address);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'd0);
            total++;
            if (bus.Inst_Address !== 32'd8 || bus.if_id_pc !== 32'd4
                || bus.if_id_instruction !== 32'h0000_0B93 || bus.fetch_count !== 32'd2) begin
                bad++;
                $display("FAIL stall_hold: got addr=%h pc=%h insn=%h cnt=%0d want 8/4/00000b93/2",
                         bus.Inst_Address, bus.if_id_pc, bus.if_id_instruction, bus.fetch_count);
            end
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (bus.if_id_pc !== 32'd8 || bus.if_id_instruction !== 32'h00A0_0513) begin
            bad++;
            $display("FAIL stall_release: got %h/%h want 8/00a00513",
                     bus.if_id_pc, bus.if_id_instruction);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b0, 32'd0); // PC now 16
        step(1'b0, 1'b1, 32'h0000_002B);
        total++;
        if (bus.Inst_Address !== 32'h28 || bus.if_id_valid !== 1'b0
            || bus.if_id_instruction !== NOP) begin
            bad++;
            $display("FAIL flush_bubble: got addr=%h valid=%0b insn=%h want 28/0/%h",
                     bus.Inst_Address, bus.if_id_valid, bus.if_id_instruction, NOP);
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (bus.if_id_pc !== 32'h28 || bus.if_id_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_target: got %h/%0b want 28/1", bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_flush_stall();
        logic [31:0] cnt;
        cnt = bus.fetch_count;
        step(1'b1, 1'b1, 32'h0000_0004);
        total++;
        if (bus.Inst_Address !== 32'd4 || bus.if_id_valid !== 1'b0 || bus.fetch_count !== m_count) begin
            bad++;
            $display("FAIL flush_over_stall: got addr=%h valid=%0b cnt=%0d want 4/0/%0d",
                     bus.Inst_Address, bus.if_id_valid, bus.fetch_count, cnt);
        end
    endtask

    task automatic test_end_of_program();
        do_reset();
        for (int i = 0; i < 21; i++) step(1'b0, 1'b0, 32'd0);
        total++;
        if (bus.if_id_pc !== 32'd80 || bus.if_id_valid !== 1'b1) begin
            bad++;
            $display("FAIL end_last: got %h/%0b want 80/1", bus.if_id_pc, bus.if_id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0);
            total++;
            if (bus.Inst_Address !== 32'd84 || bus.fetch_done !== 1'b1 || bus.if_id_valid !== 1'b0
                || bus.fetch_count !== 32'd21) begin
                bad++;
                $display("FAIL end_halt: got addr=%0d done=%0b valid=%0b cnt=%0d want 84/1/0/21",
                         bus.Inst_Address, bus.fetch_done, bus.if_id_valid, bus.fetch_count);
            end
        end
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (bus.if_id_pc !== 32'd0 || bus.if_id_instruction !== 32'h0000_0B13
            || bus.if_id_valid !== 1'b1 || bus.fetch_done !== 1'b0) begin
            bad++;
            $display("FAIL end_restart: got %h/%h/%0b done=%0b want 0/00000b13/1 done=0",
                     bus.if_id_pc, bus.if_id_instruction, bus.if_id_valid, bus.fetch_done);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (bus.Inst_Address !== 32'd0 || bus.if_id_valid !== 1'b0 || bus.fetch_count !== 32'd0
            || bus.if_id_instruction !== NOP) begin
            bad++;
            $display("FAIL async_rst: got addr=%h valid=%0b cnt=%0d insn=%h want 0/0/0/%h",
                     bus.Inst_Address, bus.if_id_valid, bus.fetch_count, bus.if_id_instruction, NOP);
        end
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (bus.if_id_pc !== 32'd0 || bus.if_id_valid !== 1'b1) begin
            bad++;
            $display("FAIL async_first: got %h/%0b want 0/1", bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic s;
        logic f;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            step(s, f, 32'($urandom_range(0, 100)));
            total++;
            if (bus.Inst_Address !== m_pc || bus.fetch_count !== m_count
                || bus.fetch_done !== m_done()) begin
                bad++;
                $display("FAIL b2b_state: got addr=%h cnt=%0d done=%0b want %h/%0d/%0b",
                         bus.Inst_Address, bus.fetch_count, bus.fetch_done,
                         m_pc, m_count, m_done());
            end
        end
    endtask

    initial begin
        clk               = 1'b0;
        reset             = 1'b1;
        total             = 0;
        bad               = 0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = 32'd0;
        for (int i = 0; i < 21; i++) rom[i] = 32'h1000_0000 + 32'(i);
        rom[0] = 32'h0000_0B13;
        rom[1] = 32'h0000_0B93;
        rom[2] = 32'h00A0_0513;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_ifid  = '{pc: 32'd0, insn: NOP, valid: 1'b0, chk_pc: 1'b1};

        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_flush_stall();
        test_end_of_program();
        test_async_reset();
        test_back_to_back();

        repeat (2) @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
